// File: rtl/alarm_seq_pkg.sv
// rtl/alarm_seq_pkg.sv - alarm sequencer state encoding, BCD wrap limits and BCD/binary helpers
package alarm_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARMED  = 3'd1,
    S_RING   = 3'd2,
    S_SNOOZE = 3'd3,
    S_DONE   = 3'd4
  } state_e;

  localparam logic [7:0] MIN_WRAP = 8'h59;
  localparam logic [7:0] HR_WRAP  = 8'h23;

  function automatic logic [6:0] bcd2bin(input logic [7:0] b);
    return 7'(b[7:4]) * 7'd10 + 7'(b[3:0]);
  endfunction

  function automatic logic [7:0] bin2bcd(input logic [6:0] v);
    return {4'(v / 7'd10), 4'(v % 7'd10)};
  endfunction

endpackage

// File: rtl/bcd_time_add.sv
// rtl/bcd_time_add.sv - combinational BCD HH:MM plus binary minutes (<60), wrapping at 59 min and 23 h
module bcd_time_add
  import alarm_seq_pkg::*;
(
  input  logic [15:0] time_in,
  input  logic [5:0]  add_min,
  output logic [15:0] time_out
);

  logic [6:0] min_sum;
  logic [6:0] min_wrapped;
  logic [6:0] hr_sum;
  logic [6:0] hr_wrapped;
  logic       carry;

  // Work in binary per field; the addend is below 60 so at most one wrap per field.
  always_comb begin
    min_sum     = bcd2bin(time_in[7:0]) + {1'b0, add_min};
    carry       = min_sum > bcd2bin(MIN_WRAP);
    min_wrapped = carry ? min_sum - 7'd60 : min_sum;
    hr_sum      = bcd2bin(time_in[15:8]) + {6'd0, carry};
    hr_wrapped  = (hr_sum > bcd2bin(HR_WRAP)) ? hr_sum - 7'd24 : hr_sum;
    time_out    = {bin2bcd(hr_wrapped), bin2bcd(min_wrapped)};
  end

endmodule

// File: rtl/alarm_sequencer.sv
// rtl/alarm_sequencer.sv - alarm ring/snooze/dismiss sequencer; ALARM_AUTO_SNOOZE_EN makes ring timeout act as snooze
module alarm_sequencer
  import alarm_seq_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 100000000,
  parameter int unsigned RING_SECS  = 300,
  parameter int unsigned SNOOZE_MIN = 5,
  parameter int unsigned MAX_SNOOZE = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alarm_en,
  input  logic [15:0] clock_val,
  input  logic [15:0] alarm_val,
  input  logic        snooze,
  input  logic        dismiss,
  output logic        player_en,
  output logic        ringing,
  output logic        snoozing,
  output logic [1:0]  snooze_cnt,
  output logic [15:0] next_ring
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int RW = $clog2(RING_SECS + 1);
`ifdef ALARM_AUTO_SNOOZE_EN
  localparam bit AUTO_SNOOZE = 1'b1;
`else
  localparam bit AUTO_SNOOZE = 1'b0;
`endif

  state_e          state_q, state_d;
  logic [15:0]     next_ring_q, next_ring_d;
  logic [1:0]      snooze_cnt_q, snooze_cnt_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [RW-1:0]   ring_sec_q, ring_sec_d;
  logic            player_en_q, ringing_q, snoozing_q;
  logic [15:0]     snooze_time;
  logic            sec_tick;
  logic            timeout;
  logic            can_snooze;

  bcd_time_add u_bcd_time_add (
    .time_in  (clock_val),
    .add_min  (6'(SNOOZE_MIN)),
    .time_out (snooze_time)
  );

  always_comb begin
    state_d      = state_q;
    next_ring_d  = next_ring_q;
    snooze_cnt_d = snooze_cnt_q;
    presc_d      = '0;
    ring_sec_d   = '0;
    sec_tick     = (state_q == S_RING) && (presc_q == PW'(CLK_HZ - 1));
    // Fire on the tick that would take the counter to RING_SECS so ringing lasts exactly RING_SECS s.
    timeout      = sec_tick && (ring_sec_q == RW'(RING_SECS - 1));
    can_snooze   = snooze_cnt_q < 2'(MAX_SNOOZE);

    unique case (state_q)
      S_IDLE: begin
        next_ring_d = alarm_val;
        if (alarm_en) state_d = S_ARMED;
      end
      S_ARMED: begin
        next_ring_d = alarm_val;
        if (clock_val == next_ring_q) state_d = S_RING;
      end
      S_RING: begin
        presc_d    = sec_tick ? '0 : presc_q + PW'(1);
        ring_sec_d = ring_sec_q + RW'(sec_tick);
        if (dismiss) begin
          state_d = S_DONE;
        end else if (snooze || (AUTO_SNOOZE && timeout)) begin
          if (can_snooze) begin
            state_d      = S_SNOOZE;
            next_ring_d  = snooze_time;
            snooze_cnt_d = snooze_cnt_q + 2'd1;
          end else begin
            state_d = S_DONE;
          end
        end else if (timeout) begin
          state_d = S_DONE;
        end
      end
      S_SNOOZE: begin
        if (clock_val == next_ring_q) state_d = S_RING;
      end
      S_DONE: begin
        snooze_cnt_d = 2'd0;
        next_ring_d  = alarm_val;
        // Hold off re-arming until the alarm minute has passed.
        if (clock_val != alarm_val) state_d = S_ARMED;
      end
      default: state_d = S_IDLE;
    endcase

    if (!alarm_en) begin
      state_d      = S_IDLE;
      next_ring_d  = alarm_val;
      snooze_cnt_d = 2'd0;
      presc_d      = '0;
      ring_sec_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      next_ring_q  <= 16'h0000;
      snooze_cnt_q <= 2'd0;
      presc_q      <= '0;
      ring_sec_q   <= '0;
      player_en_q  <= 1'b0;
      ringing_q    <= 1'b0;
      snoozing_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      next_ring_q  <= next_ring_d;
      snooze_cnt_q <= snooze_cnt_d;
      presc_q      <= presc_d;
      ring_sec_q   <= ring_sec_d;
      player_en_q  <= (state_d == S_RING);
      ringing_q    <= (state_d == S_RING);
      snoozing_q   <= (state_d == S_SNOOZE);
    end
  end

  assign player_en  = player_en_q;
  assign ringing    = ringing_q;
  assign snoozing   = snoozing_q;
  assign snooze_cnt = snooze_cnt_q;
  assign next_ring  = next_ring_q;

endmodule

// File: tb/tb_alarm_sequencer.sv
// tb/tb_alarm_sequencer.sv - self-checking bench for alarm_sequencer and bcd_time_add
module tb_alarm_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        alarm_en;
  logic [15:0] clock_val;
  logic [15:0] alarm_val;
  logic        snooze;
  logic        dismiss;
  logic        player_en;
  logic        ringing;
  logic        snoozing;
  logic [1:0]  snooze_cnt;
  logic [15:0] next_ring;

  logic [15:0] add_in;
  logic [5:0]  add_min;
  logic [15:0] add_out;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    string       tag;
    logic [20:0] exp;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  alarm_sequencer #(
    .CLK_HZ     (10),
    .RING_SECS  (4),
    .SNOOZE_MIN (5),
    .MAX_SNOOZE (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .alarm_en   (alarm_en),
    .clock_val  (clock_val),
    .alarm_val  (alarm_val),
    .snooze     (snooze),
    .dismiss    (dismiss),
    .player_en  (player_en),
    .ringing    (ringing),
    .snoozing   (snoozing),
    .snooze_cnt (snooze_cnt),
    .next_ring  (next_ring)
  );

  bcd_time_add u_add (
    .time_in  (add_in),
    .add_min  (add_min),
    .time_out (add_out)
  );

  function automatic logic [20:0] st(bit pe, bit ri, bit sn, logic [1:0] c, logic [15:0] nr);
    return {pe, ri, sn, c, nr};
  endfunction

  // Push the expected output snapshot, advance n edges, then pop and compare.
  task automatic cycle(int n, string tag, logic [20:0] exp);
    exp_t e;
    logic [20:0] obs;
    sb.push_back('{tag: tag, exp: exp});
    repeat (n) @(posedge clk);
    #1;
    e   = sb.pop_front();
    obs = {player_en, ringing, snoozing, snooze_cnt, next_ring};
    tests_run++;
    assert (obs === e.exp) else begin
      tests_failed++;
      $error("FAIL %s observed {pe,ri,sn,cnt,nr}=%h expected=%h", e.tag, obs, e.exp);
    end
  endtask

  initial begin
    int tot;
    int eh;
    int em;
    logic [15:0] exp_t16;

    rst       = 1'b1;
    alarm_en  = 1'b0;
    clock_val = 16'h0659;
    alarm_val = 16'h0700;
    snooze    = 1'b0;
    dismiss   = 1'b0;

    for (int h = 0; h < 24; h++) begin
      for (int m = 0; m < 60; m++) begin
        for (int a = 1; a < 60; a++) begin
          add_in  = {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
          add_min = 6'(a);
          #1;
          tot     = (h * 60 + m + a) % 1440;
          eh      = tot / 60;
          em      = tot % 60;
          exp_t16 = {4'(eh / 10), 4'(eh % 10), 4'(em / 10), 4'(em % 10)};
          tests_run++;
          assert (add_out === exp_t16) else begin
            tests_failed++;
            $error("FAIL bcd_add %h+%0d observed=%h expected=%h", add_in, a, add_out, exp_t16);
          end
        end
      end
    end

    @(negedge clk);
    cycle(1, "reset", st(0, 0, 0, 2'd0, 16'h0000));

    rst = 1'b0; alarm_en = 1'b1;
    cycle(1, "arm", st(0, 0, 0, 2'd0, 16'h0700));
    cycle(1, "armed_no_match", st(0, 0, 0, 2'd0, 16'h0700));
    clock_val = 16'h0700;
    cycle(1, "ring_entry", st(1, 1, 0, 2'd0, 16'h0700));

    snooze = 1'b1;
    cycle(1, "snooze1", st(0, 0, 1, 2'd1, 16'h0705));
    snooze = 1'b0; dismiss = 1'b1;
    cycle(1, "dismiss_in_snooze_ignored", st(0, 0, 1, 2'd1, 16'h0705));
    dismiss = 1'b0; clock_val = 16'h0705;
    cycle(1, "ring2", st(1, 1, 0, 2'd1, 16'h0705));
    snooze = 1'b1;
    cycle(1, "snooze2", st(0, 0, 1, 2'd2, 16'h0710));
    snooze = 1'b0; clock_val = 16'h0710;
    cycle(1, "ring3", st(1, 1, 0, 2'd2, 16'h0710));
    snooze = 1'b1;
    cycle(1, "snooze3", st(0, 0, 1, 2'd3, 16'h0715));
    snooze = 1'b0; clock_val = 16'h0715;
    cycle(1, "ring4", st(1, 1, 0, 2'd3, 16'h0715));
    snooze = 1'b1;
    cycle(1, "snooze4_done", st(0, 0, 0, 2'd3, 16'h0715));
    snooze = 1'b0;
    cycle(1, "done_clears_cnt", st(0, 0, 0, 2'd0, 16'h0700));

    alarm_val = 16'h2358;
    cycle(1, "armed_tracks_alarm", st(0, 0, 0, 2'd0, 16'h2358));
    clock_val = 16'h2358;
    cycle(1, "ring_2358", st(1, 1, 0, 2'd0, 16'h2358));
    snooze = 1'b1;
    cycle(1, "snooze_wrap", st(0, 0, 1, 2'd1, 16'h0003));
    snooze = 1'b0; alarm_val = 16'h1234;
    cycle(1, "alarm_change_in_snooze", st(0, 0, 1, 2'd1, 16'h0003));
    clock_val = 16'h2359;
    cycle(1, "no_ring_2359", st(0, 0, 1, 2'd1, 16'h0003));
    clock_val = 16'h0003;
    cycle(1, "ring_0003", st(1, 1, 0, 2'd1, 16'h0003));
    snooze = 1'b1; dismiss = 1'b1;
    cycle(1, "snooze_dismiss_done", st(0, 0, 0, 2'd1, 16'h0003));
    snooze = 1'b0; dismiss = 1'b0;
    cycle(1, "done_rearm", st(0, 0, 0, 2'd0, 16'h1234));

    clock_val = 16'h1234;
    cycle(1, "ring_1234", st(1, 1, 0, 2'd0, 16'h1234));
    alarm_en = 1'b0; snooze = 1'b1;
    cycle(1, "alarm_en_off_priority", st(0, 0, 0, 2'd0, 16'h1234));
    alarm_en = 1'b1; snooze = 1'b0;
    cycle(1, "idle_to_armed", st(0, 0, 0, 2'd0, 16'h1234));
    cycle(1, "ring_after_rearm", st(1, 1, 0, 2'd0, 16'h1234));
    snooze = 1'b1;
    cycle(1, "snooze_1239", st(0, 0, 1, 2'd1, 16'h1239));
    snooze = 1'b0; rst = 1'b1;
    cycle(1, "rst_mid_snooze", st(0, 0, 0, 2'd0, 16'h0000));
    rst = 1'b0; clock_val = 16'h1000;
    cycle(1, "post_rst_arm", st(0, 0, 0, 2'd0, 16'h1234));
    snooze = 1'b1; dismiss = 1'b1;
    cycle(1, "events_in_armed_ignored", st(0, 0, 0, 2'd0, 16'h1234));
    snooze = 1'b0; dismiss = 1'b0;

    clock_val = 16'h1234;
    cycle(1, "ring_for_timeout", st(1, 1, 0, 2'd0, 16'h1234));
    cycle(39, "ring_before_timeout", st(1, 1, 0, 2'd0, 16'h1234));
`ifdef ALARM_AUTO_SNOOZE_EN
    cycle(1, "timeout_auto_snooze", st(0, 0, 1, 2'd1, 16'h1239));
`else
    cycle(1, "timeout_done", st(0, 0, 0, 2'd0, 16'h1234));
`endif
    cycle(3, "no_retrigger_same_minute", st(0, 0, 0, 2'd0, 16'h1234));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
